instr_loader: RTL and testbench



---
 rtl/instr_loader.sv | 131 +++++++++++++
 tb/tb_instr_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot loader: takes a length-prefixed byte stream, assembles little-endian
// 32-bit words, writes them to instruction memory and then releases the CPU.
module instr_loader #(
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_LAST,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        n_q, n_d;
  logic [1:0]         b_q, b_d;
  logic [23:0]        part_q, part_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wd_q, wd_d;
  logic [15:0]        n_full;
  logic               accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LEN0;
      n_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      b_q     <= b_d;
      part_q  <= part_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    b_d     = b_q;
    part_d  = part_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wd_d    = wd_q;
    accept  = byte_valid && byte_ready;
    n_full  = {byte_data, n_q[7:0]};

    case (state_q)
      S_LEN0: begin
        if (accept) begin
          n_d[7:0] = byte_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          n_d[15:8] = byte_data;
          if (n_full == 16'd0) begin
            state_d = S_DONE;
          end else if (32'(n_full) > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          b_d = b_q + 2'd1;
          // The 4th byte goes straight into the write register, so the word
          // store overlaps reception of the next word without stalling.
          if (b_q == 2'd3) begin
            wd_d   = {byte_data, part_q};
            addr_d = 32'(idx_q) << 2;
            we_d   = 1'b1;
            idx_d  = idx_q + IDX_W'(1);
            if (32'(idx_q) + 32'd1 == 32'(n_q)) begin
              state_d = S_LAST;
            end
          end else begin
            part_d[{b_q, 3'b000} +: 8] = byte_data;
          end
        end
      end
      S_LAST:  state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_LEN0;
    endcase
  end

  // Ready depends only on registered state (and rst), never on byte_valid.
  always_comb begin
    byte_ready = !rst && ((state_q == S_LEN0) || (state_q == S_LEN1) ||
                          (state_q == S_DATA));
    mem_we     = we_q;
    mem_addr   = addr_q;
    mem_wd     = wd_q;
    cpu_rst    = (state_q != S_DONE);
    done       = (state_q == S_DONE);
    err        = (state_q == S_ERR);
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader against a stream-level model.
module tb_instr_loader;

  localparam int unsigned MAXW = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_rst;
  logic        done;
  logic        err;

  instr_loader #(.MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_wd[$];
  int          wide_pulses = 0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(mem_addr);
      got_wd.push_back(mem_wd);
      if (prev_we === 1'b1) wide_pulses++;
    end
    prev_we = mem_we;
  end

  logic [7:0]  stim[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_wd[$];
  int          exp_accept;
  bit          exp_done;
  bit          exp_err;
  bit          exp_zero;

  // Reference: decode the whole stream into the list of memory writes.
  function automatic void model();
    int unsigned n;
    exp_addr.delete();
    exp_wd.delete();
    n = int'({stim[1], stim[0]});
    exp_err  = (n > MAXW);
    exp_done = !exp_err;
    exp_zero = (n == 0);
    exp_accept = (exp_zero || exp_err) ? 2 : 2 + 4 * int'(n);
    if (!exp_err) begin
      for (int unsigned i = 0; i < n; i++) begin
        exp_addr.push_back(4 * i);
        exp_wd.push_back({stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]});
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got_addr.delete();
    got_wd.delete();
    wide_pulses = 0;
  endtask

  task automatic send(input int count, input int mingap, input int maxgap, output bit ok);
    int g;
    int t;
    ok = 1'b1;
    for (int i = 0; i < count && ok; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, mingap)) : 0;
      repeat (g) begin
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = stim[i];
      t = 0;
      while (byte_ready !== 1'b1 && t < 16) begin
        @(negedge clk);
        t++;
      end
      if (byte_ready !== 1'b1) ok = 1'b0;
      else @(posedge clk);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic test_load(input string name, input int mingap, input int maxgap);
    bit ok;
    model();
    send(exp_accept, mingap, maxgap, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_handshake: byte_ready never rose within 16 cycles", name);
    end
    checks++;
    if (done !== (exp_done && exp_zero) || err !== exp_err) begin
      failures++;
      $display("FAIL %s_status_k1: done=%b err=%b required done=%b err=%b",
               name, done, err, exp_done && exp_zero, exp_err);
    end
    @(negedge clk);
    checks++;
    if (done !== exp_done || cpu_rst !== !exp_done || err !== exp_err || byte_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_status_k2: done=%b cpu_rst=%b err=%b ready=%b required %b %b %b 0",
               name, done, cpu_rst, err, byte_ready, exp_done, !exp_done, exp_err);
    end
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      failures++;
      $display("FAIL %s_write_count: got %0d required %0d", name, got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_wd[i] !== exp_wd[i]) begin
        failures++;
        $display("FAIL %s_write%0d: addr=%h wd=%h required addr=%h wd=%h",
                 name, i, got_addr[i], got_wd[i], exp_addr[i], exp_wd[i]);
      end
    end
    checks++;
    if (wide_pulses !== 0) begin
      failures++;
      $display("FAIL %s_we_width: %0d multi-cycle pulses required 0", name, wide_pulses);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wd !== 32'h0 ||
        cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: ready=%b we=%b addr=%h wd=%h cpu_rst=%b done=%b err=%b required 0 0 0 0 1 0 0",
               byte_ready, mem_we, mem_addr, mem_wd, cpu_rst, done, err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      failures++;
      $display("FAIL reset_len0: ready=%b cpu_rst=%b required 1 1", byte_ready, cpu_rst);
    end
  endtask

  task automatic set_normal_stream();
    stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
  endtask

  task automatic test_normal();
    do_reset();
    set_normal_stream();
    test_load("normal", 0, 0);
    checks++;
    if (got_addr.size() != 2 || got_addr[0] !== 32'h0 || got_wd[0] !== 32'h00A00513 ||
        got_addr[1] !== 32'h4 || got_wd[1] !== 32'h00B00593) begin
      failures++;
      $display("FAIL normal_literal: %0d writes, w0=%h@%h w1=%h@%h required 00a00513@0 00b00593@4",
               got_addr.size(), got_wd[0], got_addr[0], got_wd[1], got_addr[1]);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    set_normal_stream();
    test_load("gaps", 1, 3);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n = int'($urandom_range(8, 1));
      stim = '{8'(n), 8'h00};
      for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
      test_load("random", 0, 2);
    end
  endtask

  task automatic test_max_len();
    do_reset();
    stim = '{8'(MAXW), 8'h00};
    for (int i = 0; i < 4 * int'(MAXW); i++) stim.push_back(8'($urandom));
    test_load("max_len", 0, 0);
  endtask

  task automatic test_zero();
    do_reset();
    stim = '{8'h00, 8'h00};
    test_load("zero", 0, 0);
  endtask

  task automatic test_overlength();
    do_reset();
    stim = '{8'h41, 8'h00};
    test_load("overlength", 0, 0);
    for (int i = 0; i < 8; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0 || mem_we !== 1'b0 || err !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL overlength_hold%0d: ready=%b we=%b err=%b cpu_rst=%b done=%b required 0 0 1 1 0",
                 i, byte_ready, mem_we, err, cpu_rst, done);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    set_normal_stream();
    send(8, 0, 0, ok);
    @(negedge clk);
    checks++;
    if (!ok || got_addr.size() != 1 || got_addr[0] !== 32'h0 || got_wd[0] !== 32'h00A00513 ||
        cpu_rst !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_partial: ok=%b writes=%0d w0=%h@%h cpu_rst=%b done=%b required 1 1 00a00513@0 1 0",
               ok, got_addr.size(), got_wd[0], got_addr[0], cpu_rst, done);
    end
    do_reset();
    stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    test_load("reset_mid_reload", 0, 1);
    checks++;
    if (got_addr.size() != 1 || got_addr[0] !== 32'h0 || got_wd[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL reset_mid_literal: writes=%0d w0=%h@%h required deadbeef@0",
               got_addr.size(), got_wd[0], got_addr[0]);
    end
  endtask

  task automatic test_after_done();
    do_reset();
    stim = '{8'h01, 8'h00};
    for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
    test_load("after_done", 0, 0);
    for (int i = 0; i < 10; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b1 || cpu_rst !== 1'b0) begin
        failures++;
        $display("FAIL after_done%0d: ready=%b we=%b done=%b cpu_rst=%b required 0 0 1 0",
                 i, byte_ready, mem_we, done, cpu_rst);
      end
    end
    byte_valid = 1'b0;
    checks++;
    if (got_addr.size() != 1) begin
      failures++;
      $display("FAIL after_done_writes: got %0d required 1", got_addr.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_normal();
    test_gaps();
    test_random();
    test_max_len();
    test_zero();
    test_overlength();
    test_reset_mid();
    test_after_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
